// File: rtl/bmc_m10_top.sv
// Board-management-controller SPI endpoint: an ingress SPI master driven by a local
// request port, and an egress SPI slave that serves a local register file.
module bmc_m10_top #(
    parameter int CLK_DIV   = 4,
    parameter int REG_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        ingr_spi_clk,
    output logic        ingr_spi_csn,
    output logic        ingr_spi_mosi,
    input  logic        ingr_spi_miso,
    input  logic        egrs_spi_clk,
    input  logic        egrs_spi_csn,
    input  logic        egrs_spi_mosi,
    output logic        egrs_spi_miso,
    output logic        egr_wr_valid,
    output logic [7:0]  egr_wr_addr,
    output logic [31:0] egr_wr_data
);

    localparam int CW = $clog2(2 * CLK_DIV) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(2 * CLK_DIV - 1);
    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(REG_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } ingr_state_t;

    ingr_state_t    state_r;
    logic [CW-1:0]  cnt_r;
    logic [5:0]     bit_r;
    logic [46:0]    tx_r;
    logic [31:0]    rx_r;
    logic           we_r;
    logic [47:0]    req_word_s;

    // Assemble the outgoing frame; reads carry a zero data field.
    always_comb begin
        req_word_s = 48'h0;
        if (req_we) begin
            req_word_s = {8'h02, req_addr, req_wdata};
        end else begin
            req_word_s = {8'h03, req_addr, 32'h0};
        end
    end

    // Ingress master sequencer: SETUP, 48 SCLK periods, HOLD, inter-frame GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            bit_r         <= 6'd0;
            tx_r          <= 47'h0;
            rx_r          <= 32'h0;
            we_r          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rdata         <= 32'h0;
            ingr_spi_clk  <= 1'b0;
            ingr_spi_csn  <= 1'b1;
            ingr_spi_mosi <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        tx_r          <= req_word_s[46:0];
                        ingr_spi_mosi <= req_word_s[47];
                        we_r          <= req_we;
                        busy          <= 1'b1;
                        ingr_spi_csn  <= 1'b0;
                        cnt_r         <= '0;
                        state_r       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == DIV_LAST) begin
                        cnt_r        <= '0;
                        bit_r        <= 6'd0;
                        ingr_spi_clk <= 1'b1;
                        rx_r         <= {rx_r[30:0], ingr_spi_miso};
                        state_r      <= ST_SHIFT;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r != DIV_LAST) begin
                        cnt_r <= cnt_r + 1'b1;
                    end else begin
                        cnt_r <= '0;
                        if (ingr_spi_clk) begin
                            // Falling edge: present the next bit, zeros drain out after bit 0.
                            ingr_spi_clk  <= 1'b0;
                            ingr_spi_mosi <= tx_r[46];
                            tx_r          <= {tx_r[45:0], 1'b0};
                        end else if (bit_r == 6'd47) begin
                            state_r <= ST_HOLD;
                        end else begin
                            ingr_spi_clk <= 1'b1;
                            rx_r         <= {rx_r[30:0], ingr_spi_miso};
                            bit_r        <= bit_r + 6'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == DIV_LAST) begin
                        cnt_r        <= '0;
                        ingr_spi_csn <= 1'b1;
                        state_r      <= ST_GAP;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r   <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                        if (!we_r) begin
                            rdata <= rx_r;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cnt_r         <= '0;
                    busy          <= 1'b0;
                    ingr_spi_clk  <= 1'b0;
                    ingr_spi_csn  <= 1'b1;
                    ingr_spi_mosi <= 1'b0;
                end
            endcase
        end
    end

    logic [1:0]  sclk_sync_r;
    logic [1:0]  csn_sync_r;
    logic [1:0]  mosi_sync_r;
    logic        sclk_prev_r;
    logic        csn_prev_r;
    logic [5:0]  e_cnt_r;
    logic [30:0] e_sh_r;
    logic [7:0]  e_addr_r;
    logic        e_read_r;
    logic        e_write_r;
    logic [31:0] e_rd_word_r;
    logic [31:0] regs_r [REG_DEPTH];

    logic        sclk_rise_s;
    logic        sclk_fall_s;
    logic        csn_fall_s;
    logic        csn_s;
    logic        mosi_s;
    logic [15:0] hdr_s;
    logic [31:0] rd_lookup_s;
    logic [31:0] wr_data_s;
    logic        wr_in_range_s;

    // Bring the egress pins into the clk domain; csn idles high so reset is not a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_r <= 2'b00;
            csn_sync_r  <= 2'b11;
            mosi_sync_r <= 2'b00;
            sclk_prev_r <= 1'b0;
            csn_prev_r  <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[0], egrs_spi_clk};
            csn_sync_r  <= {csn_sync_r[0], egrs_spi_csn};
            mosi_sync_r <= {mosi_sync_r[0], egrs_spi_mosi};
            sclk_prev_r <= sclk_sync_r[1];
            csn_prev_r  <= csn_sync_r[1];
        end
    end

    // Edge detection plus header decode and register-file lookup.
    always_comb begin
        sclk_rise_s   = sclk_sync_r[1] & ~sclk_prev_r;
        sclk_fall_s   = ~sclk_sync_r[1] & sclk_prev_r;
        csn_s         = csn_sync_r[1];
        csn_fall_s    = ~csn_sync_r[1] & csn_prev_r;
        mosi_s        = mosi_sync_r[1];
        hdr_s         = {e_sh_r[14:0], mosi_s};
        wr_data_s     = {e_sh_r[30:0], mosi_s};
        wr_in_range_s = ({1'b0, e_addr_r} < DEPTH_W);
        rd_lookup_s   = 32'hDEAD_BEEF;
        if ({1'b0, hdr_s[7:0]} < DEPTH_W) begin
            rd_lookup_s = regs_r[hdr_s[AW-1:0]];
        end else begin
            rd_lookup_s = 32'hDEAD_BEEF;
        end
    end

    // Egress slave: bit counting, read-word shift-out and write commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_cnt_r       <= 6'd0;
            e_sh_r        <= 31'h0;
            e_addr_r      <= 8'h0;
            e_read_r      <= 1'b0;
            e_write_r     <= 1'b0;
            e_rd_word_r   <= 32'h0;
            egrs_spi_miso <= 1'b0;
            egr_wr_valid  <= 1'b0;
            egr_wr_addr   <= 8'h0;
            egr_wr_data   <= 32'h0;
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs_r[i] <= 32'h0;
            end
        end else begin
            egr_wr_valid <= 1'b0;
            if (csn_s) begin
                e_cnt_r       <= 6'd0;
                e_read_r      <= 1'b0;
                e_write_r     <= 1'b0;
                egrs_spi_miso <= 1'b0;
            end else if (csn_fall_s) begin
                e_cnt_r   <= 6'd0;
                e_read_r  <= 1'b0;
                e_write_r <= 1'b0;
            end else if (sclk_rise_s && (e_cnt_r != 6'd48)) begin
                e_sh_r  <= {e_sh_r[29:0], mosi_s};
                e_cnt_r <= e_cnt_r + 6'd1;
                if (e_cnt_r == 6'd15) begin
                    e_addr_r    <= hdr_s[7:0];
                    e_read_r    <= (hdr_s[15:8] == 8'h03);
                    e_write_r   <= (hdr_s[15:8] == 8'h02);
                    e_rd_word_r <= rd_lookup_s;
                end else if ((e_cnt_r == 6'd47) && e_write_r) begin
                    egr_wr_valid <= 1'b1;
                    egr_wr_addr  <= e_addr_r;
                    egr_wr_data  <= wr_data_s;
                    if (wr_in_range_s) begin
                        regs_r[e_addr_r[AW-1:0]] <= wr_data_s;
                    end
                end
            end else if (sclk_fall_s) begin
                if (e_read_r && (e_cnt_r >= 6'd16) && (e_cnt_r <= 6'd47)) begin
                    egrs_spi_miso <= e_rd_word_r[31];
                    e_rd_word_r   <= {e_rd_word_r[30:0], 1'b0};
                end else begin
                    egrs_spi_miso <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bmc_m10_top.sv
// Directed bench for bmc_m10_top: ingress master frames, egress slave register access, reset.
module tb_bmc_m10_top;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        ingr_spi_clk;
    logic        ingr_spi_csn;
    logic        ingr_spi_mosi;
    logic        ingr_spi_miso;
    logic        egrs_spi_clk;
    logic        egrs_spi_csn;
    logic        egrs_spi_mosi;
    logic        egrs_spi_miso;
    logic        egr_wr_valid;
    logic [7:0]  egr_wr_addr;
    logic [31:0] egr_wr_data;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          sclk_rises = 0;
    int          rise_base = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    int          rel;
    logic        loop_en = 1'b0;
    logic [47:0] rd_frame = 48'h0;
    logic [47:0] mosi_cap = 48'h0;
    logic [7:0]  wr_addr_seen = 8'h0;
    logic [31:0] wr_data_seen = 32'h0;
    logic        miso_drv;

    always #5 clk = ~clk;

    bmc_m10_top #(.CLK_DIV(4), .REG_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata),
        .ingr_spi_clk(ingr_spi_clk), .ingr_spi_csn(ingr_spi_csn),
        .ingr_spi_mosi(ingr_spi_mosi), .ingr_spi_miso(ingr_spi_miso),
        .egrs_spi_clk(egrs_spi_clk), .egrs_spi_csn(egrs_spi_csn),
        .egrs_spi_mosi(egrs_spi_mosi), .egrs_spi_miso(egrs_spi_miso),
        .egr_wr_valid(egr_wr_valid), .egr_wr_addr(egr_wr_addr), .egr_wr_data(egr_wr_data)
    );

    // Ingress slave model: either loop mosi back or serve rd_frame MSB first.
    always_comb begin
        rel = sclk_rises - rise_base;
        miso_drv = 1'b0;
        if (rel >= 0 && rel < 48) miso_drv = rd_frame[47 - rel];
    end
    assign ingr_spi_miso = loop_en ? ingr_spi_mosi : miso_drv;

    always @(posedge ingr_spi_clk) begin
        sclk_rises <= sclk_rises + 1;
        mosi_cap   <= {mosi_cap[46:0], ingr_spi_mosi};
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (egr_wr_valid) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_seen <= egr_wr_addr;
            wr_data_seen <= egr_wr_data;
        end
    end

    task automatic ingr_run(input logic we, input logic [7:0] a, input logic [31:0] d,
                            input bit poke, output int cyc, output logic busy_after);
        rise_base = sclk_rises;
        @(negedge clk);
        req = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        busy_after = busy;
        cyc = 1;
        while (!done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 50) begin
                req = 1'b1; req_we = 1'b1;
            end else begin
                req = 1'b0;
            end
        end
    endtask

    task automatic egr_xfer(input logic [47:0] tx, input int nbits,
                            output logic [47:0] rx, output int lat);
        rx = 48'h0;
        lat = 0;
        @(negedge clk);
        egrs_spi_csn = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            egrs_spi_mosi = tx[47 - i];
            repeat (HALF) @(negedge clk);
            rx = {rx[46:0], egrs_spi_miso};
            egrs_spi_clk = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (lat == 0 && egr_wr_valid) lat = k;
            end
            egrs_spi_clk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        egrs_spi_csn = 1'b1;
        egrs_spi_mosi = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        tests_run++;
        if ({busy, done, rdata, ingr_spi_clk, ingr_spi_csn, ingr_spi_mosi} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL reset_ingress: got busy=%b done=%b rdata=%h sclk=%b csn=%b mosi=%b, want 0 0 0 0 1 0",
                     busy, done, rdata, ingr_spi_clk, ingr_spi_csn, ingr_spi_mosi);
            tests_failed++;
        end
        tests_run++;
        if ({egrs_spi_miso, egr_wr_valid, egr_wr_addr, egr_wr_data} !== {1'b0, 1'b0, 8'h0, 32'h0}) begin
            $display("FAIL reset_egress: got miso=%b valid=%b addr=%h data=%h, want all zero",
                     egrs_spi_miso, egr_wr_valid, egr_wr_addr, egr_wr_data);
            tests_failed++;
        end
    endtask

    task automatic test_ingress_read();
        int cyc; logic b; int d0;
        loop_en = 1'b0;
        rd_frame = {8'h00, 8'h00, 32'hA5A5_5A5A};
        d0 = done_cnt;
        ingr_run(1'b0, 8'h3C, 32'hFFFF_FFFF, 1'b1, cyc, b);
        tests_run++;
        if (b !== 1'b1) begin $display("FAIL rd_busy_rise: got %b want 1", b); tests_failed++; end
        tests_run++;
        if (cyc != 401) begin $display("FAIL rd_frame_len: got %0d want 401", cyc); tests_failed++; end
        tests_run++;
        if (rdata !== 32'hA5A5_5A5A) begin $display("FAIL rd_rdata: got %h want a5a55a5a", rdata); tests_failed++; end
        tests_run++;
        if (mosi_cap !== {8'h03, 8'h3C, 32'h0}) begin
            $display("FAIL rd_mosi: got %h want 033c00000000", mosi_cap); tests_failed++;
        end
        repeat (30) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 != 1 || ingr_spi_csn !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL rd_req_while_busy: got dones=%0d csn=%b busy=%b want 1 1 0",
                     done_cnt - d0, ingr_spi_csn, busy); tests_failed++;
        end
    endtask

    task automatic test_ingress_write();
        int cyc; logic b;
        loop_en = 1'b1;
        ingr_run(1'b1, 8'h10, 32'hCAFE_F00D, 1'b0, cyc, b);
        tests_run++;
        if (cyc != 401) begin $display("FAIL wr_frame_len: got %0d want 401", cyc); tests_failed++; end
        tests_run++;
        if (sclk_rises - rise_base != 48) begin
            $display("FAIL wr_sclk_periods: got %0d want 48", sclk_rises - rise_base); tests_failed++;
        end
        tests_run++;
        if (mosi_cap !== {8'h02, 8'h10, 32'hCAFE_F00D}) begin
            $display("FAIL wr_mosi: got %h want 0210cafef00d", mosi_cap); tests_failed++;
        end
        tests_run++;
        if (rdata !== 32'hA5A5_5A5A) begin $display("FAIL wr_rdata_kept: got %h want a5a55a5a", rdata); tests_failed++; end
        loop_en = 1'b0;
    endtask

    task automatic test_egress_write_read();
        logic [47:0] rx; int lat; int w0;
        w0 = wr_cnt;
        egr_xfer({8'h02, 8'h05, 32'h1234_5678}, 48, rx, lat);
        tests_run++;
        if (wr_cnt - w0 != 1 || wr_addr_seen !== 8'h05 || wr_data_seen !== 32'h1234_5678) begin
            $display("FAIL egr_write: got pulses=%0d addr=%h data=%h want 1 05 12345678",
                     wr_cnt - w0, wr_addr_seen, wr_data_seen); tests_failed++;
        end
        tests_run++;
        if (lat != 3) begin $display("FAIL egr_wr_latency: got %0d want 3", lat); tests_failed++; end
        egr_xfer({8'h03, 8'h05, 32'h0}, 48, rx, lat);
        tests_run++;
        if (rx !== {16'h0, 32'h1234_5678}) begin
            $display("FAIL egr_read: got %h want 000012345678", rx); tests_failed++;
        end
    endtask

    task automatic test_egress_out_of_range();
        logic [47:0] rx; int lat; int w0;
        egr_xfer({8'h03, 8'h20, 32'h0}, 48, rx, lat);
        tests_run++;
        if (rx[31:0] !== 32'hDEAD_BEEF) begin $display("FAIL egr_oor_read: got %h want deadbeef", rx[31:0]); tests_failed++; end
        w0 = wr_cnt;
        egr_xfer({8'h02, 8'h20, 32'h0000_55AA}, 48, rx, lat);
        tests_run++;
        if (wr_cnt - w0 != 1 || wr_addr_seen !== 8'h20 || wr_data_seen !== 32'h0000_55AA) begin
            $display("FAIL egr_oor_write: got pulses=%0d addr=%h data=%h want 1 20 000055aa",
                     wr_cnt - w0, wr_addr_seen, wr_data_seen); tests_failed++;
        end
        egr_xfer({8'h03, 8'h00, 32'h0}, 48, rx, lat);
        tests_run++;
        if (rx[31:0] !== 32'h0) begin $display("FAIL egr_oor_alias: got %h want 00000000", rx[31:0]); tests_failed++; end
    endtask

    task automatic test_egress_abort();
        logic [47:0] rx; int lat; int w0;
        w0 = wr_cnt;
        egr_xfer({8'h02, 8'h05, 32'hFFFF_FFFF}, 30, rx, lat);
        tests_run++;
        if (wr_cnt != w0) begin $display("FAIL egr_abort_pulse: got %0d pulses want 0", wr_cnt - w0); tests_failed++; end
        egr_xfer({8'h03, 8'h05, 32'h0}, 48, rx, lat);
        tests_run++;
        if (rx[31:0] !== 32'h1234_5678) begin $display("FAIL egr_abort_data: got %h want 12345678", rx[31:0]); tests_failed++; end
    endtask

    task automatic test_rst_mid_frame();
        logic [47:0] rx; int lat; int d0;
        d0 = done_cnt;
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_addr = 8'h44; req_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        req = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (ingr_spi_csn !== 1'b1 || ingr_spi_clk !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rst_mid_frame: got csn=%b sclk=%b busy=%b want 1 0 0", ingr_spi_csn, ingr_spi_clk, busy);
            tests_failed++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        tests_run++;
        if (done_cnt != d0 || ingr_spi_csn !== 1'b1) begin
            $display("FAIL rst_no_done: got dones=%0d csn=%b want 0 1", done_cnt - d0, ingr_spi_csn); tests_failed++;
        end
        egr_xfer({8'h03, 8'h05, 32'h0}, 48, rx, lat);
        tests_run++;
        if (rx[31:0] !== 32'h0) begin $display("FAIL rst_regfile_clear: got %h want 00000000", rx[31:0]); tests_failed++; end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = 8'h0; req_wdata = 32'h0;
        egrs_spi_clk = 1'b0; egrs_spi_csn = 1'b1; egrs_spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        test_ingress_read();
        test_ingress_write();
        test_egress_write_read();
        test_egress_out_of_range();
        test_egress_abort();
        test_rst_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bmc_m10_top.md
# bmc_m10_top

Behavioural-synthesizable board-management-controller (BMC) endpoint that connects to the FPGA PMCI SPI pins in the top-level simulation. The block has two SPI links. The ingress link is an SPI master: the BMC drives sclk/csn/mosi into the FPGA. The egress link is an SPI slave: the FPGA masters and the BMC answers from a local register file. A simple local request port launches ingress transactions, and an observation port reports egress writes.

## Interface
- CLK_DIV, 4: ingress SCLK half-period in clk cycles (≥2); SCLK = clk/(2·CLK_DIV).
- REG_DEPTH, 16: egress register-file words (power of 2, ≤256).
- clk  in  1  single block clock. Egress SCLK must be ≤ clk/8.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  start ingress transaction; accepted only when busy=0.
- req_we  in  1  1=write (opcode 0x02), 0=read (opcode 0x03).
- req_addr  in  8  ingress address byte.
- req_wdata  in  32  ingress write data.
- busy  out  1  ingress transaction in progress.
- done  out  1  one-cycle pulse at end of ingress frame.
- rdata  out  32  ingress read data; valid from done until the next done.
- ingr_spi_clk  out  1  ingress SCLK.
- ingr_spi_csn  out  1  ingress chip select, active low.
- ingr_spi_mosi  out  1  ingress master-out data.
- ingr_spi_miso  in  1  ingress master-in data.
- egrs_spi_clk  in  1  egress SCLK from the FPGA.
- egrs_spi_csn  in  1  egress chip select, active low.
- egrs_spi_mosi  in  1  egress data from the FPGA.
- egrs_spi_miso  out  1  egress data to the FPGA.
- egr_wr_valid  out  1  one-cycle pulse when an egress write commits.
- egr_wr_addr  out  8  address of the committed write.
- egr_wr_data  out  32  data of the committed write.

## Operation
- Frame format on both links:
  - SPI mode 0: CPOL=0, CPHA=0, MSB first.
  - 48 bits total: opcode[7:0], addr[7:0], data[31:0].
  - Data is sampled on the SCLK rising edge and changed on the falling edge.
- Write frame (opcode 0x02): data travels on mosi.
- Read frame (opcode 0x03): data travels on miso during bits 16–47, MSB first.

**Ingress master FSM:** IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: csn=1, sclk=0. On req with busy=0, latch the shift word {opcode, addr, wdata or 0} and go to SETUP. busy rises the cycle after req.
- SETUP: csn=0. mosi = bit 47. Stay CLK_DIV cycles.
- SHIFT: 48 SCLK periods, each high CLK_DIV cycles then low CLK_DIV cycles.
  - miso is sampled at each rising edge into a 48-bit register.
  - mosi advances at each falling edge.
- HOLD: sclk=0, csn=0 for CLK_DIV cycles.
- GAP: csn=1 for 2·CLK_DIV cycles.
- Exit from GAP: done pulses, rdata = sampled bits [31:0] (read) or is left unchanged (write), busy falls, return to IDLE.
- req while busy=1 is ignored.

**Egress slave:**
- egrs_spi_clk, csn and mosi each pass through a 2-flop synchronizer; edges are detected in the clk domain.
- csn falling: clear the bit counter.
- Each SCLK rising edge: shift mosi in and increment the bit counter.
- After bit 15: decode opcode and addr.
  - Opcode 0x03: load the read word. Use regfile[addr] if addr < REG_DEPTH, else 32'hDEAD_BEEF.
- miso updates on SCLK falling edges only.
  - Bits 16–47 of a read: MSB-first read word.
  - All other times: 0.
- Opcode 0x02 at the 48th rising edge: commit when addr < REG_DEPTH, and pulse egr_wr_valid with addr/data in either case.
  - Out-of-range addresses do not modify the register file.
- Other opcodes: frame ignored.
- csn rising before bit 48: frame aborted, no write, miso returns to 0. Bits beyond 48 are ignored.
- Register file resets to all zeros.

## Timing
- Reset values: busy=0, done=0, rdata=0, ingr_spi_clk=0, ingr_spi_csn=1, ingr_spi_mosi=0, egrs_spi_miso=0, egr_wr_valid=0, egr_wr_addr=0, egr_wr_data=0.
- Ingress frame length, req to done: 1 + CLK_DIV + 96·CLK_DIV + CLK_DIV + 2·CLK_DIV cycles. That is 401 cycles at CLK_DIV=4.
- Egress response latency:
  - egr_wr_valid asserts 3 clk cycles after the raw 48th SCLK rising edge (2 synchronizer stages + 1 register).
  - miso changes 3 clk cycles after the raw falling edge.
- rst mid-frame: everything returns to its reset value immediately, with no done and no write.
- egrs_spi_csn held high: all egress SCLK activity is ignored.

## Test plan
- Egress write 0x02/0x05/0x1234_5678 then read 0x03/0x05 → egr_wr_valid with addr 0x05 / data 0x1234_5678; read returns 0x1234_5678 on miso.
- Egress read of addr 0x20 with REG_DEPTH=16 → 0xDEAD_BEEF. A write to addr 0x20 pulses egr_wr_valid but a later read of addr 0x00 is still 0.
- Egress write aborted by csn high after 30 bits → no egr_wr_valid; read of that address is unchanged.
- Ingress write req_addr=0x10, wdata=0xCAFE_F00D, loopback mosi→miso → 48 SCLK periods with mosi bits 0x02,0x10,0xCAFEF00D; done at cycle 401.
- Ingress read with miso driven 0xA5A5_5A5A during the data phase → rdata=0xA5A5_5A5A at done; req while busy is ignored.
- rst asserted mid ingress frame → csn=1, sclk=0, busy=0 immediately; no done.
